// File: rtl/fetch_issue.sv
// Instruction fetch/issue front end: fetches 9-bit words from instruction memory,
// presents them with a valid/ready handshake, tracks the PC and stops on HALT.
module fetch_issue #(
  parameter int unsigned          PC_W     = 8,
  parameter logic [PC_W-1:0]      RESET_PC = '0,
  parameter int unsigned          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [8:0]       imem_rdata,
  input  logic             imem_rvalid,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [3:0]       opcode,
  output logic [1:0]       format,
  output logic             imm_flag,
  output logic [1:0]       operand,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_target,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] HALT_OP = 4'b1110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALTED
  } state_t;

  state_t state;

  // The read address is always the architectural PC.
  assign imem_addr = pc;

  // imem_req is raised on entry to FETCH so it is high for exactly that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      issue_valid <= 1'b0;
      opcode      <= 4'b0;
      format      <= 2'b0;
      imm_flag    <= 1'b0;
      operand     <= 2'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc       <= RESET_PC;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          imem_req <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            opcode      <= imem_rdata[8:5];
            format      <= imem_rdata[4:3];
            imm_flag    <= imem_rdata[2];
            operand     <= imem_rdata[1:0];
            issue_valid <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue_ready) begin
            issue_valid <= 1'b0;
            if (instr_count != '1) begin
              instr_count <= instr_count + CNT_W'(1);
            end
            if (opcode == HALT_OP) begin
              halted <= 1'b1;
              state  <= S_HALTED;
            end else begin
              pc       <= redirect_valid ? redirect_target : pc + PC_W'(1);
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
          end
        end
        S_HALTED: begin
          imem_req    <= 1'b0;
          issue_valid <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
